// File: rtl/fetch_queue_unit_pkg.sv
// Shared types and constants for the fetch queue unit: instruction field
// positions (bit 0 is the instruction MSB), fetch FSM states, queue entry layout.
package fetch_pkg;

    localparam int INST_W     = 32;
    localparam int PC_W       = 32;   // widest PC carried in a queue entry
    localparam int OPCODE_MSB = 0;
    localparam int OPCODE_LSB = 5;
    localparam int FUNC_MSB   = 26;
    localparam int FUNC_LSB   = 31;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [0:INST_W-1] data;
        logic [PC_W-1:0]   pc;
    } fetch_entry_t;

    // Unsigned add that sticks at all-ones instead of wrapping.
    function automatic logic [31:0] satAdd32(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
    endfunction

endpackage

// File: rtl/fetch_queue_unit_if.sv
// Fetch unit bus: instruction-memory request/response, redirect and decode channel.
// master = fetch unit side, slave = memory/pipeline side.
interface fetch_queue_unit_if #(
    parameter int ADDR_W = 32
);
    logic                           imem_req_valid;
    logic                           imem_req_ready;
    logic [ADDR_W-1:0]              imem_req_addr;
    logic                           imem_resp_valid;
    logic [0:fetch_pkg::INST_W-1]   imem_resp_data;
    logic                           redirect_valid;
    logic [ADDR_W-1:0]              redirect_pc;
    logic                           inst_valid;
    logic                           inst_ready;
    logic [0:fetch_pkg::INST_W-1]   inst_data;
    logic [ADDR_W-1:0]              inst_pc;
    logic [ADDR_W-1:0]              PCPlusFour;
    logic [5:0]                     OpCode;
    logic [5:0]                     Function;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready, imem_resp_valid, imem_resp_data,
        input  redirect_valid, redirect_pc, inst_ready,
        output inst_valid, inst_data, inst_pc, PCPlusFour, OpCode, Function
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready, imem_resp_valid, imem_resp_data,
        output redirect_valid, redirect_pc, inst_ready,
        input  inst_valid, inst_data, inst_pc, PCPlusFour, OpCode, Function
    );
endinterface

// File: rtl/fetch_queue_unit_inst_queue.sv
// Synchronous FIFO with a registered head word; flush beats push and pop.
// The head register holds its last value while the queue is empty.
module inst_queue #(
    parameter int DEPTH = 4,
    parameter int W     = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic [W-1:0]           pushData,
    input  logic                   pop,
    input  logic                   flush,
    output logic [W-1:0]           headData,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [W-1:0]     mem_r [DEPTH];
    logic [PTR_W-1:0] rdPtr_r, wrPtr_r, rdNext_s;
    logic [CNT_W-1:0] count_r, countNext_s;
    logic [W-1:0]     head_r, headNext_s;
    logic             doPush_s, doPop_s;

    assign full     = (count_r == CNT_W'(DEPTH));
    assign empty    = (count_r == CNT_W'(0));
    assign count    = count_r;
    assign headData = head_r;

    // Next pointers/count and the word that becomes head after this edge.
    always_comb begin
        doPush_s = push && !flush && (!full || pop);
        doPop_s  = pop && !flush && !empty;
        rdNext_s = doPop_s ? (rdPtr_r + PTR_W'(1)) : rdPtr_r;
        if (flush) begin
            countNext_s = CNT_W'(0);
        end else begin
            countNext_s = count_r + CNT_W'(doPush_s) - CNT_W'(doPop_s);
        end
        if (doPush_s && (wrPtr_r == rdNext_s)) begin
            headNext_s = pushData;
        end else begin
            headNext_s = mem_r[rdNext_s];
        end
    end

    // Storage array; contents are only read behind a valid count.
    always_ff @(posedge clk) begin
        if (doPush_s) begin
            mem_r[wrPtr_r] <= pushData;
        end
    end

    // Pointers, occupancy and head register.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdPtr_r <= PTR_W'(0);
            wrPtr_r <= PTR_W'(0);
            count_r <= CNT_W'(0);
            head_r  <= W'(0);
        end else if (flush) begin
            rdPtr_r <= PTR_W'(0);
            wrPtr_r <= PTR_W'(0);
            count_r <= CNT_W'(0);
        end else begin
            if (doPush_s) begin
                wrPtr_r <= wrPtr_r + PTR_W'(1);
            end
            rdPtr_r <= rdNext_s;
            count_r <= countNext_s;
            if (countNext_s != CNT_W'(0)) begin
                head_r <= headNext_s;
            end
        end
    end

endmodule

// File: rtl/fetch_queue_unit.sv
// Instruction fetch with PC ownership, credit-limited memory requests and a decode queue.
// Optional FETCH_PERF_CNT_EN adds saturating fetched/dropped counters.
module fetch_queue_unit
    import fetch_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
    input  logic               clk,
    input  logic               reset,
    fetch_queue_unit_if.master bus
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]        perf_fetched,
    output logic [31:0]        perf_dropped
`endif
);
    localparam int         CNT_W   = $clog2(DEPTH) + 1;
    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_REQ  = REQ;
    localparam logic [1:0] ST_WAIT = WAIT;

    logic [1:0]        state_r, stateNext_s;
    logic [ADDR_W-1:0] pc_r, pcNext_s, reqAddr_r;
    logic              drop_r, dropNext_s;
    logic              handshake_s, respTaken_s, pushEn_s, popEn_s, discard_s;
    logic              idleCredit_s, respCredit_s;
    logic [CNT_W-1:0]  qCount_s, countAfter_s;
    logic              qFull_s, qEmpty_s;
    fetch_entry_t      pushEntry_s, headEntry_s;

    // Handshakes and credit; a redirect flushes the queue, kills this cycle's response and pop.
    always_comb begin
        handshake_s = (state_r == ST_REQ) && bus.imem_req_ready;
        respTaken_s = (state_r == ST_WAIT) && bus.imem_resp_valid;
        discard_s   = respTaken_s && (drop_r || bus.redirect_valid);
        popEn_s     = !qEmpty_s && bus.inst_ready && !bus.redirect_valid;
        pushEn_s    = respTaken_s && !drop_r && !bus.redirect_valid && (!qFull_s || popEn_s);
        if (bus.redirect_valid) begin
            countAfter_s = CNT_W'(0);
        end else begin
            countAfter_s = qCount_s + CNT_W'(pushEn_s) - CNT_W'(popEn_s);
        end
        idleCredit_s     = (qCount_s < CNT_W'(DEPTH));
        respCredit_s     = (countAfter_s < CNT_W'(DEPTH));
        pushEntry_s.data = bus.imem_resp_data;
        pushEntry_s.pc   = PC_W'(reqAddr_r);
    end

    // Fetch FSM next state, PC and stale-response flag.
    always_comb begin
        stateNext_s = state_r;
        pcNext_s    = pc_r;
        dropNext_s  = drop_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.redirect_valid) begin
                    pcNext_s    = bus.redirect_pc;
                    stateNext_s = ST_REQ;
                end else if (idleCredit_s) begin
                    stateNext_s = ST_REQ;
                end else begin
                    stateNext_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                // An outstanding old-address request is marked stale; PC then already holds the target.
                if (bus.redirect_valid) begin
                    pcNext_s   = bus.redirect_pc;
                    dropNext_s = 1'b1;
                end else if (handshake_s && !drop_r) begin
                    pcNext_s = pc_r + ADDR_W'(32'd4);
                end else begin
                    pcNext_s = pc_r;
                end
                if (handshake_s) begin
                    stateNext_s = ST_WAIT;
                end else begin
                    stateNext_s = ST_REQ;
                end
            end
            ST_WAIT: begin
                if (bus.redirect_valid) begin
                    pcNext_s = bus.redirect_pc;
                end else begin
                    pcNext_s = pc_r;
                end
                if (respTaken_s) begin
                    dropNext_s  = 1'b0;
                    stateNext_s = respCredit_s ? ST_REQ : ST_IDLE;
                end else begin
                    dropNext_s  = drop_r || bus.redirect_valid;
                    stateNext_s = ST_WAIT;
                end
            end
            default: begin
                stateNext_s = ST_IDLE;
                pcNext_s    = pc_r;
                dropNext_s  = 1'b0;
            end
        endcase
    end

    // FSM registers; the request address is captured on entry to REQ and held until accepted.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            pc_r      <= RESET_PC;
            reqAddr_r <= RESET_PC;
            drop_r    <= 1'b0;
        end else begin
            state_r <= stateNext_s;
            pc_r    <= pcNext_s;
            drop_r  <= dropNext_s;
            if ((stateNext_s == ST_REQ) && (state_r != ST_REQ)) begin
                reqAddr_r <= pcNext_s;
            end
        end
    end

    inst_queue #(
        .DEPTH (DEPTH),
        .W     ($bits(fetch_entry_t))
    ) uQueue (
        .clk      (clk),
        .reset    (reset),
        .push     (pushEn_s),
        .pushData (pushEntry_s),
        .pop      (popEn_s),
        .flush    (bus.redirect_valid),
        .headData (headEntry_s),
        .count    (qCount_s),
        .full     (qFull_s),
        .empty    (qEmpty_s)
    );

    assign bus.imem_req_valid = (state_r == ST_REQ);
    assign bus.imem_req_addr  = reqAddr_r;
    assign bus.inst_valid     = !qEmpty_s;
    assign bus.inst_data      = headEntry_s.data;
    assign bus.inst_pc        = headEntry_s.pc[ADDR_W-1:0];
    assign bus.PCPlusFour     = headEntry_s.pc[ADDR_W-1:0] + ADDR_W'(32'd4);
    assign bus.OpCode         = headEntry_s.data[OPCODE_MSB:OPCODE_LSB];
    assign bus.Function       = headEntry_s.data[FUNC_MSB:FUNC_LSB];

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] dropInc_s;

    // Dropped work this cycle: a discarded response plus every entry a redirect flushes.
    always_comb begin
        if (bus.redirect_valid) begin
            dropInc_s = 32'(discard_s) + 32'(qCount_s);
        end else begin
            dropInc_s = 32'(discard_s);
        end
    end

    // Saturating performance counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_fetched <= 32'd0;
            perf_dropped <= 32'd0;
        end else begin
            perf_fetched <= satAdd32(perf_fetched, 32'(pushEn_s));
            perf_dropped <= satAdd32(perf_dropped, dropInc_s);
        end
    end
`else
    logic unusedDiscard_s;
    assign unusedDiscard_s = discard_s;
`endif

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Directed bench for fetch_queue_unit: table-driven fetch stream plus hand-written
// sequences for backpressure, redirects, reset in flight and (optionally) perf counters.
module tb_fetch_queue_unit;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fetch_queue_unit_if #(.ADDR_W(32)) bus ();

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched, perf_dropped;
`endif

    fetch_queue_unit #(.ADDR_W(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetched (perf_fetched),
        .perf_dropped (perf_dropped)
`endif
    );

    int checks = 0;
    int errors = 0;

    logic        pend;
    logic [31:0] pendAddr;
    logic        autoResp;
    logic [31:0] reqLog [$];
    logic [31:0] popPc [$];
    logic [31:0] popData [$];

    typedef struct {
        int unsigned holdCycles;
        logic [31:0] expPc;
        logic [31:0] expData;
        logic [5:0]  expOp;
        logic [5:0]  expFunc;
        logic [31:0] expPcp4;
    } vec_t;

    vec_t vecs [4];

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return 32'h20A4_0020 + (a << 4);
    endfunction

    function automatic logic [31:0] popPcAt(input int i);
        return (i < popPc.size()) ? popPc[i] : 32'hDEAD_BEEF;
    endfunction

    function automatic logic [31:0] popDataAt(input int i);
        return (i < popData.size()) ? popData[i] : 32'hDEAD_BEEF;
    endfunction

    function automatic logic [31:0] reqAt(input int i);
        return (i < reqLog.size()) ? reqLog[i] : 32'hDEAD_BEEF;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One clock: memory model answers, handshakes/pops are logged, outputs sampled 1ns after the edge.
    task automatic tick();
        logic hs, pp;
        logic [31:0] a;
        hs = bus.imem_req_valid && bus.imem_req_ready;
        pp = bus.inst_valid && bus.inst_ready && !bus.redirect_valid;
        a  = bus.imem_req_addr;
        bus.imem_resp_valid = pend && autoResp;
        bus.imem_resp_data  = memWord(pendAddr);
        if (hs) reqLog.push_back(a);
        if (pp) begin
            popPc.push_back(bus.inst_pc);
            popData.push_back(bus.inst_data);
        end
        if (pend && autoResp) pend = 1'b0;
        @(posedge clk);
        #1;
        bus.imem_resp_valid = 1'b0;
        if (hs) begin
            pend     = 1'b1;
            pendAddr = a;
        end
    endtask

    task automatic clearLogs();
        reqLog.delete();
        popPc.delete();
        popData.delete();
    endtask

    task automatic doReset();
        reset              = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        bus.imem_req_ready = 1'b0;
        bus.inst_ready     = 1'b0;
        pend               = 1'b0;
        autoResp           = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        clearLogs();
    endtask

    task automatic waitReqAddr(input string name, input logic [31:0] a, input int budget);
        int n = 0;
        while (!(bus.imem_req_valid && bus.imem_req_addr == a) && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if (n >= budget) begin
            errors++;
            $display("FAIL %s: request for 0x%0h not seen within %0d cycles", name, a, budget);
        end
    endtask

    task automatic waitValid(input string name, input int budget);
        int n = 0;
        while (!bus.inst_valid && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if (n >= budget) begin
            errors++;
            $display("FAIL %s: inst_valid not seen within %0d cycles", name, budget);
        end
    endtask

    task automatic waitPops(input string name, input int cnt, input int budget);
        int n = 0;
        while (popPc.size() < cnt && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if (n >= budget) begin
            errors++;
            $display("FAIL %s: %0d pops seen, wanted %0d", name, popPc.size(), cnt);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{0, 32'h0000_0000, 32'h20A4_0020, 6'h08, 6'h20, 32'h0000_0004};
        vecs[1] = '{2, 32'h0000_0004, 32'h20A4_0060, 6'h08, 6'h20, 32'h0000_0008};
        vecs[2] = '{0, 32'h0000_0008, 32'h20A4_00A0, 6'h08, 6'h20, 32'h0000_000C};
        vecs[3] = '{1, 32'h0000_000C, 32'h20A4_00E0, 6'h08, 6'h20, 32'h0000_0010};

        bus.imem_resp_valid = 1'b0;
        bus.imem_resp_data  = 32'h0;

        // Reset values.
        reset              = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        bus.imem_req_ready = 1'b0;
        bus.inst_ready     = 1'b0;
        pend               = 1'b0;
        autoResp           = 1'b1;
        tick();
        tick();
        check("rst_req_valid", bus.imem_req_valid, 1'b0);
        check("rst_inst_valid", bus.inst_valid, 1'b0);
        check("rst_inst_data", bus.inst_data, 32'h0);
        check("rst_inst_pc", bus.inst_pc, 32'h0);
        check("rst_opcode", bus.OpCode, 6'h0);
        check("rst_function", bus.Function, 6'h0);

        // Table-driven stream: memory ready with 1-cycle response.
        doReset();
        bus.imem_req_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.inst_ready = 1'b0;
            repeat (vecs[i].holdCycles) tick();
            bus.inst_ready = 1'b1;
            waitValid($sformatf("a_valid%0d", i), 20);
            check($sformatf("a_pc%0d", i), bus.inst_pc, vecs[i].expPc);
            check($sformatf("a_data%0d", i), bus.inst_data, vecs[i].expData);
            check($sformatf("a_op%0d", i), bus.OpCode, vecs[i].expOp);
            check($sformatf("a_func%0d", i), bus.Function, vecs[i].expFunc);
            check($sformatf("a_pcp4_%0d", i), bus.PCPlusFour, vecs[i].expPcp4);
            tick();
        end
        check("a_req0", reqAt(0), 32'h0);
        check("a_req1", reqAt(1), 32'h4);
        check("a_req2", reqAt(2), 32'h8);

        // Decode stalled: exactly DEPTH requests, then one pop frees one more.
        doReset();
        bus.imem_req_ready = 1'b1;
        repeat (30) tick();
        check("b_req_count", reqLog.size(), 4);
        check("b_req3", reqAt(3), 32'hC);
        check("b_req_valid_full", bus.imem_req_valid, 1'b0);
        check("b_head_pc", bus.inst_pc, 32'h0);
        bus.inst_ready = 1'b1;
        tick();
        bus.inst_ready = 1'b0;
        repeat (10) tick();
        check("b_req_count_after_pop", reqLog.size(), 5);
        check("b_req4", reqAt(4), 32'h10);

        // Redirect while waiting on the response for 0x8.
        doReset();
        bus.imem_req_ready = 1'b1;
        bus.inst_ready     = 1'b1;
        waitReqAddr("c_wait8", 32'h8, 40);
        autoResp = 1'b0;
        tick();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h100;
        tick();
        bus.redirect_valid = 1'b0;
        autoResp           = 1'b1;
        waitPops("c_pops", 3, 40);
        check("c_pop1", popPcAt(1), 32'h4);
        check("c_pop2", popPcAt(2), 32'h100);
        check("c_pop2_data", popDataAt(2), memWord(32'h100));
        check("c_req3", reqAt(3), 32'h100);

        // Memory stalled 3 cycles with a redirect in the middle.
        doReset();
        bus.imem_req_ready = 1'b1;
        bus.inst_ready     = 1'b1;
        waitReqAddr("d_wait4", 32'h4, 40);
        bus.imem_req_ready = 1'b0;
        tick();
        check("d_hold1", bus.imem_req_addr, 32'h4);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h200;
        tick();
        bus.redirect_valid = 1'b0;
        check("d_hold2", bus.imem_req_addr, 32'h4);
        check("d_hold2_valid", bus.imem_req_valid, 1'b1);
        tick();
        check("d_hold3", bus.imem_req_addr, 32'h4);
        bus.imem_req_ready = 1'b1;
        waitReqAddr("d_wait200", 32'h200, 40);
        check("d_req1", reqAt(1), 32'h4);
        waitPops("d_pops", 2, 40);
        check("d_pop0", popPcAt(0), 32'h0);
        check("d_pop1", popPcAt(1), 32'h200);

        // Redirect coinciding with the response.
        doReset();
        bus.imem_req_ready = 1'b1;
        bus.inst_ready     = 1'b1;
        waitReqAddr("e_wait8", 32'h8, 40);
        tick();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h300;
        tick();
        bus.redirect_valid = 1'b0;
        waitPops("e_pops", 3, 40);
        check("e_pop2", popPcAt(2), 32'h300);
        check("e_pop2_data", popDataAt(2), memWord(32'h300));
        check("e_req3", reqAt(3), 32'h300);

        // Reset while waiting, then a stray response.
        doReset();
        bus.imem_req_ready = 1'b1;
        bus.inst_ready     = 1'b1;
        autoResp           = 1'b0;
        waitReqAddr("f_wait0", 32'h0, 10);
        tick();
        bus.imem_req_ready = 1'b0;
        reset = 1'b1;
        tick();
        tick();
        check("f_rst_req_valid", bus.imem_req_valid, 1'b0);
        reset    = 1'b0;
        autoResp = 1'b1;
        clearLogs();
        tick();
        check("f_stray_inst_valid", bus.inst_valid, 1'b0);
        check("f_req_valid", bus.imem_req_valid, 1'b1);
        check("f_req_addr", bus.imem_req_addr, 32'h0);
        bus.imem_req_ready = 1'b1;
        waitPops("f_pops", 1, 20);
        check("f_pop0", popPcAt(0), 32'h0);
        check("f_pop0_data", popDataAt(0), memWord(32'h0));

`ifdef FETCH_PERF_CNT_EN
        // Three pushed, one popped, two flushed plus one in flight.
        doReset();
        bus.imem_req_ready = 1'b1;
        waitReqAddr("p_waitC", 32'hC, 60);
        autoResp       = 1'b0;
        bus.inst_ready = 1'b1;
        tick();
        bus.inst_ready     = 1'b0;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h400;
        tick();
        bus.redirect_valid = 1'b0;
        autoResp           = 1'b1;
        tick();
        check("p_fetched", perf_fetched, 32'd3);
        check("p_dropped", perf_dropped, 32'd3);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
